// File: rtl/led_pattern_if.sv
// LED driver control bundle: level-sampled mode/duty in, LED drive and timebase pulse out.
interface led_pattern_if #(
    parameter int N_LEDS   = 3,
    parameter int PWM_BITS = 4
);
    logic [2*N_LEDS-1:0]        mode;
    logic [PWM_BITS*N_LEDS-1:0] duty;
    logic [N_LEDS-1:0]          led;
    logic                       tick;

    modport master (output mode, output duty, input led, input tick);
    modport slave  (input mode, input duty, output led, output tick);
endinterface

// File: rtl/led_pattern_driver.sv
// Multi-channel LED driver: off / on / blink / PWM per channel, shared blink prescaler.
// Optional PWM dimming is built only when LED_PATTERN_PWM_EN is defined; otherwise mode 11 acts as steady on.

module led_pattern_chan (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_mode,
    input  logic [1:0] i_mode_prev,
    input  logic       i_tick,
    input  logic       i_pwm_on,
    output logic       o_led
);
    logic r_ph;
    logic r_led;
    logic w_entry;
    logic w_ph_nxt;
    logic w_led_nxt;

    assign w_entry = (i_mode == 2'b10) && (i_mode_prev != 2'b10);

    always_comb begin
        w_ph_nxt  = r_ph;
        w_led_nxt = 1'b0;
        // Entry beats a coincident tick so every blink starts lit.
        if (w_entry)
            w_ph_nxt = 1'b1;
        else if (i_tick)
            w_ph_nxt = ~r_ph;
        case (i_mode)
            2'b00:   w_led_nxt = 1'b0;
            2'b01:   w_led_nxt = 1'b1;
            2'b10:   w_led_nxt = w_ph_nxt;
            default: w_led_nxt = i_pwm_on;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph  <= 1'b0;
            r_led <= 1'b0;
        end else begin
            r_ph  <= w_ph_nxt;
            r_led <= w_led_nxt;
        end
    end

    assign o_led = r_led;
endmodule

module led_pattern_driver #(
    parameter int N_LEDS   = 3,
    parameter int TICK_DIV = 5_000_000,
    parameter int PWM_BITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    led_pattern_if.slave  bus
);
    localparam int            CW  = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);

    logic [2*N_LEDS-1:0] r_mode_m;
    logic [2*N_LEDS-1:0] r_mode_s;
    logic [2*N_LEDS-1:0] r_mode_p;
    logic [CW-1:0]       r_presc;
    logic                w_tick;
    logic [N_LEDS-1:0]   w_pwm_on;
    logic [N_LEDS-1:0]   w_led;

    // Two-flop synchroniser plus one more stage to detect blink entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_m <= '0;
            r_mode_s <= '0;
            r_mode_p <= '0;
        end else begin
            r_mode_m <= bus.mode;
            r_mode_s <= r_mode_m;
            r_mode_p <= r_mode_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_presc <= '0;
        else if (r_presc == TOP)
            r_presc <= '0;
        else
            r_presc <= r_presc + 1'b1;
    end

    assign w_tick   = (r_presc == TOP);
    assign bus.tick = w_tick;

`ifdef LED_PATTERN_PWM_EN
    logic [PWM_BITS*N_LEDS-1:0] r_duty_m;
    logic [PWM_BITS*N_LEDS-1:0] r_duty_s;
    logic [PWM_BITS-1:0]        r_pwm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_duty_m <= '0;
            r_duty_s <= '0;
            r_pwm    <= '0;
        end else begin
            r_duty_m <= bus.duty;
            r_duty_s <= r_duty_m;
            r_pwm    <= r_pwm + 1'b1;
        end
    end

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_pwm
        assign w_pwm_on[gi] = (r_pwm < r_duty_s[PWM_BITS*gi +: PWM_BITS]);
    end
`else
    assign w_pwm_on = '1;
`endif

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
        led_pattern_chan u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_mode      (r_mode_s[2*gi +: 2]),
            .i_mode_prev (r_mode_p[2*gi +: 2]),
            .i_tick      (w_tick),
            .i_pwm_on    (w_pwm_on[gi]),
            .o_led       (w_led[gi])
        );
    end

    assign bus.led = w_led;
endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: directed and random mode/duty against a cycle-indexed reference model.
module tb_led_pattern_driver;
    localparam int N  = 3;
    localparam int TD = 4;
    localparam int PB = 2;
    localparam int HN = 4096;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   t      = 0;
    logic [5:0] mode_h [0:HN-1];
    logic [5:0] duty_h [0:HN-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    led_pattern_if #(.N_LEDS(N), .PWM_BITS(PB)) bus ();

    led_pattern_driver #(.N_LEDS(N), .TICK_DIV(TD), .PWM_BITS(PB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Mode seen by the output register at edge s (inputs sampled at edge s-2).
    function automatic logic [1:0] eff_mode(int i, int s);
        logic [5:0] v;
        if (s < 3) return 2'b00;
        v = mode_h[s-2];
        return v[2*i +: 2];
    endfunction

    function automatic logic exp_led(int i, int tt);
        logic [1:0] m;
        logic [5:0] dv;
        int e;
        int d;
        m = eff_mode(i, tt);
        case (m)
            2'b00: return 1'b0;
            2'b01: return 1'b1;
            2'b10: begin
                e = tt;
                while (e > 3 && eff_mode(i, e - 1) == 2'b10) e--;
                // Lit at entry, then inverted once per tick edge (edges that are multiples of TD).
                return (((tt / TD) - (e / TD)) % 2) == 0;
            end
            default: begin
`ifdef LED_PATTERN_PWM_EN
                dv = duty_h[tt-2];
                d  = int'(dv[PB*i +: PB]);
                return ((tt - 1) % (1 << PB)) < d;
`else
                dv = duty_h[tt-2];
                d  = int'(dv[PB*i +: PB]);
                return (d >= 0);
`endif
            end
        endcase
    endfunction

    task automatic check_model();
        logic [N-1:0] el;
        logic         et;
        for (int i = 0; i < N; i++) el[i] = exp_led(i, t);
        et = ((t % TD) == TD - 1);
        checks++;
        assert (bus.led === el) else begin
            errors++;
            $error("FAIL led t=%0d got %b exp %b", t, bus.led, el);
        end
        checks++;
        assert (bus.tick === et) else begin
            errors++;
            $error("FAIL tick t=%0d got %b exp %b", t, bus.tick, et);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert (bus.led === 3'b000) else begin
            errors++;
            $error("FAIL %s_led got %b exp 000", tag, bus.led);
        end
        checks++;
        assert (bus.tick === 1'b0) else begin
            errors++;
            $error("FAIL %s_tick got %b exp 0", tag, bus.tick);
        end
    endtask

    task automatic cyc(input logic [5:0] m, input logic [5:0] d);
        bus.mode = m;
        bus.duty = d;
        if (t + 1 < HN) begin
            mode_h[t+1] = m;
            duty_h[t+1] = d;
        end
        @(posedge clk);
        t++;
        #1;
        if (t < HN) check_model();
    endtask

    task automatic rst_cyc();
        bus.mode = 6'($urandom);
        bus.duty = 6'($urandom);
        @(posedge clk);
        #1;
        check_zero("rst");
    endtask

    // Assert reset between edges, hold it, release just after an edge.
    task automatic mid_reset(input logic [5:0] m);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async");
        bus.mode = m;
        @(posedge clk);
        #1;
        check_zero("async_hold");
        reset = 1'b0;
        t = 0;
    endtask

    initial begin
        reset    = 1'b1;
        bus.mode = '0;
        bus.duty = '0;
        #1;
        check_zero("por");
        repeat (5) rst_cyc();
        reset = 1'b0;
        t = 0;

        repeat (6) cyc(6'b000000, 6'd0);
        repeat (5) cyc(6'b000001, 6'd0);
        repeat (5) cyc(6'b000000, 6'd0);

        repeat (20) cyc(6'b001000, 6'd0);
        repeat (4) cyc(6'b000000, 6'd0);
        while (((t + 3) % TD) != 0) cyc(6'b000000, 6'd0);
        repeat (20) cyc(6'b001000, 6'd0);

        repeat (12) cyc(6'b110000, 6'b010000);
        repeat (12) cyc(6'b110000, 6'b110000);
        repeat (12) cyc(6'b110000, 6'b000000);

        repeat (3) cyc(6'b001000, 6'd0);
        checks++;
        assert (bus.led[1] === 1'b1) else begin
            errors++;
            $error("FAIL pre_reset_blink got %b exp 1", bus.led[1]);
        end
        mid_reset(6'b001000);
        repeat (20) cyc(6'b001000, 6'd0);

        for (int s = 0; s < 150; s++) begin
            logic [5:0] m;
            logic [5:0] d;
            int len;
            m   = 6'($urandom);
            d   = 6'($urandom);
            len = int'($urandom_range(1, 12));
            if (s == 75) mid_reset(m);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) d = 6'($urandom);
                cyc(m, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
